// File: rtl/stage_sequencer.sv
// Multi-cycle stage controller for the non-pipelined CPU core.
// Walks each instruction through RESET/IF/ID/EX/MEM/WB (plus a sticky HALT),
// with per-instruction EX/MEM lengths latched in ID, fetch and memory wait
// states, optional MEM bypass and a retired-instruction counter.
//
// Ports:
//   clk            - clock, all state changes on rising edge
//   reset          - synchronous active-high reset
//   if_ready       - instruction word valid; IF advances only when high
//   ex_len         - EX length for the instruction in ID (0 acts as 1)
//   mem_len        - MEM length for the instruction in ID (0 acts as 1)
//   skip_mem       - instruction in ID bypasses MEM
//   mem_ready      - memory accepted the current MEM cycle
//   halt           - halt request, sampled only in WB
//   pipeline_stage - one-hot stage {HALT,WB,MEM,EX,ID,IF,RESET}
//   cycle_count    - 0-based cycle index within EX/MEM, 0 elsewhere
//   last_cycle     - current cycle is the final one of the current stage
//   halted         - high while in HALT
//   instr_count    - number of completed WB stages (wraps)
module stage_sequencer #(
  parameter int unsigned CNT_W  = 3,
  parameter int unsigned ICNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_ready,
  input  logic [CNT_W-1:0]  ex_len,
  input  logic [CNT_W-1:0]  mem_len,
  input  logic              skip_mem,
  input  logic              mem_ready,
  input  logic              halt,
  output logic [6:0]        pipeline_stage,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              last_cycle,
  output logic              halted,
  output logic [ICNT_W-1:0] instr_count
);

  typedef enum logic [6:0] {
    StReset = 7'b0000001,
    StIf    = 7'b0000010,
    StId    = 7'b0000100,
    StEx    = 7'b0001000,
    StMem   = 7'b0010000,
    StWb    = 7'b0100000,
    StHalt  = 7'b1000000
  } state_e;

  localparam logic [CNT_W-1:0]  LenOne  = CNT_W'(1);
  localparam logic [ICNT_W-1:0] IcntOne = ICNT_W'(1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    ex_len_q, ex_len_d;
  logic [CNT_W-1:0]    mem_len_q, mem_len_d;
  logic                skip_q, skip_d;
  logic [ICNT_W-1:0]   icnt_q, icnt_d;
  logic                ex_last;
  logic                mem_last;

  // Lengths are stored as >=1, so len_q-1 never underflows.
  assign ex_last  = (cnt_q == ex_len_q - LenOne);
  assign mem_last = (cnt_q == mem_len_q - LenOne);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StReset;
      cnt_q     <= '0;
      ex_len_q  <= LenOne;
      mem_len_q <= LenOne;
      skip_q    <= 1'b0;
      icnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ex_len_q  <= ex_len_d;
      mem_len_q <= mem_len_d;
      skip_q    <= skip_d;
      icnt_q    <= icnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    ex_len_d  = ex_len_q;
    mem_len_d = mem_len_q;
    skip_d    = skip_q;
    icnt_d    = icnt_q;
    unique case (state_q)
      StReset: state_d = StIf;
      StIf: begin
        if (if_ready) state_d = StId;
      end
      StId: begin
        state_d   = StEx;
        ex_len_d  = (ex_len == '0) ? LenOne : ex_len;
        mem_len_d = (mem_len == '0) ? LenOne : mem_len;
        skip_d    = skip_mem;
      end
      StEx: begin
        if (ex_last) begin
          state_d = skip_q ? StWb : StMem;
        end else begin
          cnt_d = cnt_q + LenOne;
        end
      end
      StMem: begin
        if (!mem_ready) begin
          cnt_d = cnt_q;  // wait state: hold position
        end else if (mem_last) begin
          state_d = StWb;
        end else begin
          cnt_d = cnt_q + LenOne;
        end
      end
      StWb: begin
        icnt_d  = icnt_q + IcntOne;
        state_d = halt ? StHalt : StIf;
      end
      StHalt: state_d = StHalt;
      default: state_d = StReset;  // recover from any non-one-hot encoding
    endcase
  end

  // Outputs
  always_comb begin
    pipeline_stage = state_q;
    cycle_count    = cnt_q;
    instr_count    = icnt_q;
    halted         = (state_q == StHalt);
    last_cycle     = 1'b0;
    unique case (state_q)
      StReset, StId, StWb: last_cycle = 1'b1;
      StIf:                last_cycle = if_ready;
      StEx:                last_cycle = ex_last;
      StMem:               last_cycle = mem_ready && mem_last;
      StHalt:              last_cycle = 1'b0;
      default:             last_cycle = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: a table of per-cycle
// {inputs, expected outputs} records, applied in order; expected records go
// through a scoreboard queue and are compared mid-cycle. A second instance
// with a 2-bit instruction counter shares the stimulus to observe wrap.
module tb_stage_sequencer;

  localparam logic [6:0] R = 7'b0000001;
  localparam logic [6:0] F = 7'b0000010;
  localparam logic [6:0] D = 7'b0000100;
  localparam logic [6:0] E = 7'b0001000;
  localparam logic [6:0] M = 7'b0010000;
  localparam logic [6:0] W = 7'b0100000;
  localparam logic [6:0] H = 7'b1000000;

  typedef struct {
    logic       rst;
    logic       ifr;
    logic [2:0] exl;
    logic [2:0] meml;
    logic       skip;
    logic       memr;
    logic       hlt;
    logic       chk;
    logic [6:0] stg;
    logic [2:0] cnt;
    logic       last;
    int         icnt;
    logic       hl;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        if_ready;
  logic [2:0]  ex_len;
  logic [2:0]  mem_len;
  logic        skip_mem;
  logic        mem_ready;
  logic        halt;
  logic [6:0]  pipeline_stage;
  logic [2:0]  cycle_count;
  logic        last_cycle;
  logic        halted;
  logic [15:0] instr_count;
  logic [6:0]  stage2;
  logic [2:0]  cnt2;
  logic        last2;
  logic        halted2;
  logic [1:0]  icnt2;

  int total = 0;
  int bad   = 0;

  vec_t tbl[$];
  vec_t exp_q[$];

  stage_sequencer #(.CNT_W(3), .ICNT_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .if_ready       (if_ready),
    .ex_len         (ex_len),
    .mem_len        (mem_len),
    .skip_mem       (skip_mem),
    .mem_ready      (mem_ready),
    .halt           (halt),
    .pipeline_stage (pipeline_stage),
    .cycle_count    (cycle_count),
    .last_cycle     (last_cycle),
    .halted         (halted),
    .instr_count    (instr_count)
  );

  stage_sequencer #(.CNT_W(3), .ICNT_W(2)) dut2 (
    .clk            (clk),
    .reset          (reset),
    .if_ready       (if_ready),
    .ex_len         (ex_len),
    .mem_len        (mem_len),
    .skip_mem       (skip_mem),
    .mem_ready      (mem_ready),
    .halt           (halt),
    .pipeline_stage (stage2),
    .cycle_count    (cnt2),
    .last_cycle     (last2),
    .halted         (halted2),
    .instr_count    (icnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic add(input logic rst, input logic ifr, input logic [2:0] exl,
                     input logic [2:0] meml, input logic skip, input logic memr,
                     input logic hlt, input logic chk, input logic [6:0] stg,
                     input logic [2:0] cnt, input logic last, input int icnt,
                     input logic hl);
    vec_t v;
    v.rst = rst;   v.ifr = ifr;   v.exl = exl;   v.meml = meml;
    v.skip = skip; v.memr = memr; v.hlt = hlt;   v.chk = chk;
    v.stg = stg;   v.cnt = cnt;   v.last = last; v.icnt = icnt; v.hl = hl;
    tbl.push_back(v);
  endtask

  // Default inputs (ready, lengths 1, no skip, no halt); only expectations vary.
  task automatic nrm(input logic [6:0] stg, input logic [2:0] cnt, input logic last,
                     input int icnt);
    add(0, 1, 1, 1, 0, 1, 0, 1, stg, cnt, last, icnt, stg == H);
  endtask

  // One minimum-length instruction starting in IF with count ic.
  task automatic ins_min(input int ic);
    nrm(F, 0, 1, ic);
    nrm(D, 0, 1, ic);
    nrm(E, 0, 1, ic);
    nrm(M, 0, 1, ic);
    nrm(W, 0, 1, ic);
  endtask

  task automatic check(input int idx, input vec_t e);
    logic [15:0] ic16;
    logic [1:0]  ic2;
    ic16 = e.icnt[15:0];
    ic2  = e.icnt[1:0];
    total++;
    if (pipeline_stage !== e.stg || cycle_count !== e.cnt || last_cycle !== e.last ||
        halted !== e.hl || instr_count !== ic16 || icnt2 !== ic2 || stage2 !== e.stg ||
        cnt2 !== e.cnt || last2 !== e.last || halted2 !== e.hl) begin
      bad++;
      $display("FAIL vec%0d: got stage=%b cnt=%0d last=%b halted=%b icnt=%0d icnt2=%0d stage2=%b; want stage=%b cnt=%0d last=%b halted=%b icnt=%0d icnt2=%0d",
               idx, pipeline_stage, cycle_count, last_cycle, halted, instr_count, icnt2,
               stage2, e.stg, e.cnt, e.last, e.hl, ic16, ic2);
    end
  endtask

  initial begin
    vec_t v;
    vec_t e;
    reset = 1'b1; if_ready = 1'b0; ex_len = 3'd1; mem_len = 3'd1;
    skip_mem = 1'b0; mem_ready = 1'b1; halt = 1'b0;

    // Basic flow, all lengths 1
    add(1, 1, 1, 1, 0, 1, 0, 0, R, 0, 1, 0, 0);
    nrm(R, 0, 1, 0);
    ins_min(0);
    // Fetch wait, then RCALL-style MEM length 2 with decoder changing during EX
    add(0, 0, 1, 1, 0, 1, 0, 1, F, 0, 0, 1, 0);
    nrm(F, 0, 1, 1);
    add(0, 1, 1, 2, 0, 1, 0, 1, D, 0, 1, 1, 0);
    add(0, 1, 1, 0, 0, 1, 0, 1, E, 0, 1, 1, 0);
    nrm(M, 0, 0, 1);
    nrm(M, 1, 1, 1);
    nrm(W, 0, 1, 1);
    // EX 4, MEM 3 with two wait states at MEM index 1
    nrm(F, 0, 1, 2);
    add(0, 1, 4, 3, 0, 1, 0, 1, D, 0, 1, 2, 0);
    nrm(E, 0, 0, 2);
    nrm(E, 1, 0, 2);
    nrm(E, 2, 0, 2);
    nrm(E, 3, 1, 2);
    nrm(M, 0, 0, 2);
    add(0, 1, 1, 1, 0, 0, 0, 1, M, 1, 0, 2, 0);
    add(0, 1, 1, 1, 0, 0, 0, 1, M, 1, 0, 2, 0);
    nrm(M, 1, 0, 2);
    add(0, 1, 1, 1, 0, 0, 0, 1, M, 2, 0, 2, 0);  // wait on the final MEM cycle
    nrm(M, 2, 1, 2);
    nrm(W, 0, 1, 2);
    // skip_mem with EX 2; later skip_mem change ignored
    nrm(F, 0, 1, 3);
    add(0, 1, 2, 5, 1, 1, 0, 1, D, 0, 1, 3, 0);
    nrm(E, 0, 0, 3);
    nrm(E, 1, 1, 3);
    nrm(W, 0, 1, 3);
    // ex_len=0 acts as 1; halt in EX is ignored
    nrm(F, 0, 1, 4);
    add(0, 1, 0, 0, 1, 1, 0, 1, D, 0, 1, 4, 0);
    add(0, 1, 1, 1, 0, 1, 1, 1, E, 0, 1, 4, 0);
    nrm(W, 0, 1, 4);
    // halt in WB
    nrm(F, 0, 1, 5);
    nrm(D, 0, 1, 5);
    nrm(E, 0, 1, 5);
    nrm(M, 0, 1, 5);
    add(0, 1, 1, 1, 0, 1, 1, 1, W, 0, 1, 5, 0);
    for (int i = 0; i < 10; i++) add(0, 1, 1, 1, 0, 1, i[0], 1, H, 0, 0, 6, 1);
    add(1, 1, 1, 1, 0, 1, 0, 1, H, 0, 0, 6, 1);
    nrm(R, 0, 1, 0);
    // Three instructions, then reset at MEM index 1
    ins_min(0);
    ins_min(1);
    ins_min(2);
    nrm(F, 0, 1, 3);
    add(0, 1, 1, 3, 0, 1, 0, 1, D, 0, 1, 3, 0);
    nrm(E, 0, 1, 3);
    nrm(M, 0, 0, 3);
    add(1, 1, 1, 1, 0, 1, 0, 1, M, 1, 0, 3, 0);
    nrm(R, 0, 1, 0);
    nrm(F, 0, 1, 0);
    // Four instructions from reset: 2-bit counter wraps to 0
    nrm(D, 0, 1, 0);
    nrm(E, 0, 1, 0);
    nrm(M, 0, 1, 0);
    nrm(W, 0, 1, 0);
    ins_min(1);
    ins_min(2);
    ins_min(3);
    nrm(F, 0, 1, 4);

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      reset = v.rst; if_ready = v.ifr; ex_len = v.exl; mem_len = v.meml;
      skip_mem = v.skip; mem_ready = v.memr; halt = v.hlt;
      exp_q.push_back(v);
      @(negedge clk);
      e = exp_q.pop_front();
      if (e.chk) check(i, e);
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: leftover=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
Parametrised multi-cycle stage controller for the non-pipelined CPU core. It sequences each instruction through RESET/IF/ID/EX/MEM/WB and adds a HALT state. EX and MEM last a per-instruction number of cycles, supplied by the decoder. It also supports fetch and memory wait states, MEM bypass, and a retired-instruction counter. It drives the stage one-hot that the datapath, register file and memory interface use as enables.

Parameters:
CNT_W, 3, width of the per-stage cycle counter and of the ex_len/mem_len inputs; max stage length is 2^CNT_W-1 cycles.
ICNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
if_ready  input  1  instruction word valid; IF advances only when high.
ex_len  input  CNT_W  EX cycle count for the instruction in ID; 0 is treated as 1.
mem_len  input  CNT_W  MEM cycle count for the instruction in ID; 0 is treated as 1 (2 for RCALL/RET).
skip_mem  input  1  instruction in ID has no memory phase (EX goes straight to WB).
mem_ready  input  1  memory accepted the current MEM cycle; low inserts a wait state.
halt  input  1  halt request, sampled only in WB.
pipeline_stage  output  7  one-hot stage: bit0 RESET, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB, bit6 HALT.
cycle_count  output  CNT_W  index of the current cycle within EX or MEM (0-based); 0 in every other stage.
last_cycle  output  1  combinational; high when the current cycle is the final cycle of the current stage.
halted  output  1  high while in HALT.
instr_count  output  ICNT_W  number of completed WB stages; wraps modulo 2^ICNT_W.

Behaviour:
- Reset (synchronous, priority over everything, including mid-EX/MEM or HALT):
  - next edge gives pipeline_stage=7'b0000001, cycle_count=0, instr_count=0, halted=0, latched lengths=1, skip flag=0.
- State register holds exactly one hot bit at all times. Any illegal encoding goes to RESET on the next edge.
- RESET -> IF unconditionally (one cycle).
- IF: advance to ID when if_ready=1; otherwise stay in IF. Unbounded wait; cycle_count stays 0.
- ID:
  - always -> EX after one cycle.
  - on that edge, capture ex_len_q=max(ex_len,1), mem_len_q=max(mem_len,1), skip_q=skip_mem.
  - inputs are ignored outside ID; later decoder changes do not affect the running instruction.
- EX:
  - if cycle_count==ex_len_q-1: go to WB when skip_q=1, else MEM; cycle_count<=0.
  - otherwise stay in EX; cycle_count<=cycle_count+1.
- MEM:
  - mem_ready=0: stay in MEM, cycle_count held (wait state, not counted).
  - mem_ready=1 and cycle_count==mem_len_q-1: go to WB, cycle_count<=0.
  - mem_ready=1 otherwise: stay in MEM, cycle_count+1.
- WB:
  - one cycle; instr_count<=instr_count+1 on the exiting edge.
  - next state is HALT if halt=1, else IF.
- HALT: sticky; only reset leaves it. halted=1, cycle_count=0, instr_count frozen.
- last_cycle rules:
  - RESET, ID, WB: 1.
  - IF: equal to if_ready.
  - EX: (cycle_count==ex_len_q-1).
  - MEM: mem_ready && (cycle_count==mem_len_q-1).
  - HALT: 0.
- Width rules:
  - all comparisons use unsigned CNT_W arithmetic; cycle_count never exceeds len_q-1, so it cannot wrap.
  - instr_count wraps from 2^ICNT_W-1 to 0 with no flag.
- Latency: minimum instruction is 5 cycles (IF,ID,EX,MEM,WB with lengths 1, no waits), or 4 with skip_mem. Total cycles = 3 + IF waits + ex_len_q + (skip_q ? 0 : mem_len_q + MEM waits).
- All outputs except last_cycle are registered or decoded directly from registered state. No combinational path from inputs to pipeline_stage.

Test Plan:
- Reset then if_ready=1, ex_len=1, mem_len=1, skip_mem=0, mem_ready=1 -> stages RESET,IF,ID,EX,MEM,WB,IF; instr_count=1 after WB; last_cycle=1 every cycle.
- RCALL-style: mem_len=2 in ID, then mem_len changed to 0 during EX -> MEM lasts 2 cycles (cycle_count 0,1); latched value is used.
- ex_len=4, mem_len=3, mem_ready low for 2 cycles at MEM cycle_count=1 -> EX 4 cycles, MEM 5 cycles; cycle_count sequence in MEM 0,1,1,1,2.
- skip_mem=1, ex_len=2 -> EX lasts 2 cycles then WB directly; MEM bit never set; ex_len=0 behaves as 1.
- halt=1 asserted during EX, deasserted before WB -> no halt. halt=1 during WB -> HALT; stays for 10 cycles; reset -> RESET; instr_count=0.
- Reset asserted at MEM cycle_count=1 with ICNT_W=2 after 3 instructions -> next edge RESET state, all outputs at reset values. Separately, 4 instructions from reset -> instr_count wraps to 0.
